// File: rtl/in_reg_cell.sv
// IO input register cell: pad input synchronised into the IQC domain, optionally
// deglitched, captured under enable, with registered or bypass data and edge pulses.
module in_reg_cell #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic IQC,
  input  logic QRT,
  input  logic IP,
  input  logic IQE,
  input  logic ISEL,
  input  logic IFILT,
  output logic A2F,
  output logic A2F_RISE,
  output logic A2F_FALL,
  output logic A2F_VALID
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam int WW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES + 1) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;
  logic [WW-1:0]          r_warm;

  logic w_sync_out;
  logic w_filt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_filt     = IFILT ? r_stable : w_sync_out;

  always_ff @(posedge IQC) begin
    if (QRT) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_q      <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_warm   <= '0;
    end else begin
      r_sync[0] <= IP;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];

      // Disabling the filter discards any partial count so it restarts clean.
      if (!IFILT) begin
        r_stable <= w_sync_out;
        r_cnt    <= '0;
      end else if (w_sync_out == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_stable <= w_sync_out;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (IQE) begin
        r_q    <= w_filt;
        r_rise <= w_filt & ~r_q;
        r_fall <= ~w_filt & r_q;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end

      if (r_warm != WW'(SYNC_STAGES)) r_warm <= r_warm + 1'b1;
    end
  end

  assign A2F       = ISEL ? IP : r_q;
  assign A2F_RISE  = r_rise;
  assign A2F_FALL  = r_fall;
  assign A2F_VALID = (r_warm == WW'(SYNC_STAGES));
endmodule

// File: tb/tb_in_reg_cell.sv
// Directed bench for in_reg_cell at SYNC_STAGES=2, FILTER_LEN=4.
module tb_in_reg_cell;
  logic IQC = 1'b0;
  logic QRT, IP, IQE, ISEL, IFILT;
  logic A2F, A2F_RISE, A2F_FALL, A2F_VALID;

  int n_vec = 0;
  int n_bad = 0;

  in_reg_cell #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .IQC(IQC), .QRT(QRT), .IP(IP), .IQE(IQE), .ISEL(ISEL), .IFILT(IFILT),
    .A2F(A2F), .A2F_RISE(A2F_RISE), .A2F_FALL(A2F_FALL), .A2F_VALID(A2F_VALID)
  );

  always #5 IQC = ~IQC;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge IQC);
    #1;
  endtask

  initial begin
    QRT = 1'b1; IP = 1'b1; IQE = 1'b1; ISEL = 1'b0; IFILT = 1'b0;

    // reset with pad high
    tick(); tick();
    chk("rst_a2f", A2F, 1'b0);
    chk("rst_rise", A2F_RISE, 1'b0);
    chk("rst_fall", A2F_FALL, 1'b0);
    chk("rst_valid", A2F_VALID, 1'b0);
    ISEL = 1'b1; #1;
    chk("rst_bypass", A2F, 1'b1);
    ISEL = 1'b0; #1;
    chk("rst_nobypass", A2F, 1'b0);

    // release: valid at edge 2, data and rise at edge 3
    QRT = 1'b0;
    tick();
    chk("rel1_valid", A2F_VALID, 1'b0);
    chk("rel1_a2f", A2F, 1'b0);
    tick();
    chk("rel2_valid", A2F_VALID, 1'b1);
    chk("rel2_a2f", A2F, 1'b0);
    chk("rel2_rise", A2F_RISE, 1'b0);
    tick();
    chk("rel3_a2f", A2F, 1'b1);
    chk("rel3_rise", A2F_RISE, 1'b1);
    tick();
    chk("rel4_rise", A2F_RISE, 1'b0);
    chk("rel4_a2f", A2F, 1'b1);

    // unfiltered fall
    IP = 1'b0;
    tick(); chk("uf_n0_a2f", A2F, 1'b1);
    tick(); chk("uf_n1_a2f", A2F, 1'b1); chk("uf_n1_fall", A2F_FALL, 1'b0);
    tick(); chk("uf_n2_a2f", A2F, 1'b0); chk("uf_n2_fall", A2F_FALL, 1'b1);
    chk("uf_n2_rise", A2F_RISE, 1'b0);
    tick(); chk("uf_n3_fall", A2F_FALL, 1'b0);

    // unfiltered rise
    IP = 1'b1;
    tick(); chk("ur_n0_a2f", A2F, 1'b0);
    tick(); chk("ur_n1_a2f", A2F, 1'b0); chk("ur_n1_rise", A2F_RISE, 1'b0);
    tick(); chk("ur_n2_a2f", A2F, 1'b1); chk("ur_n2_rise", A2F_RISE, 1'b1);
    tick(); chk("ur_n3_rise", A2F_RISE, 1'b0);

    IP = 1'b0;
    repeat (4) tick();
    chk("settle0_a2f", A2F, 1'b0);

    // filter rejects a 3-cycle glitch
    IFILT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      IP = (i < 3);
      tick();
      chk("frej_a2f", A2F, 1'b0);
      chk("frej_rise", A2F_RISE, 1'b0);
    end

    // filter accepts a held level at edge 7
    IP = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("facc_wait_a2f", A2F, 1'b0);
      chk("facc_wait_rise", A2F_RISE, 1'b0);
    end
    tick(); chk("facc7_a2f", A2F, 1'b1); chk("facc7_rise", A2F_RISE, 1'b1);
    tick(); chk("facc8_rise", A2F_RISE, 1'b0); chk("facc8_a2f", A2F, 1'b1);

    // enable hold
    IFILT = 1'b0; IP = 1'b0;
    repeat (4) tick();
    chk("hold_pre_a2f", A2F, 1'b0);
    IQE = 1'b0; IP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_a2f", A2F, 1'b0);
      chk("hold_rise", A2F_RISE, 1'b0);
    end
    IQE = 1'b1;
    tick(); chk("hold_m_a2f", A2F, 1'b1); chk("hold_m_rise", A2F_RISE, 1'b1);
    tick(); chk("hold_m1_rise", A2F_RISE, 1'b0);

    // bypass follows the pad combinationally; pulses stay on the registered path
    ISEL = 1'b1; IP = 1'b0; #1;
    chk("byp_lo", A2F, 1'b0);
    IP = 1'b1; #1;
    chk("byp_hi", A2F, 1'b1);
    IP = 1'b0; #1;
    chk("byp_lo2", A2F, 1'b0);
    tick(); chk("byp_n0_fall", A2F_FALL, 1'b0);
    tick(); chk("byp_n1_fall", A2F_FALL, 1'b0);
    tick(); chk("byp_n2_fall", A2F_FALL, 1'b1); chk("byp_n2_a2f", A2F, 1'b0);
    tick(); chk("byp_n3_fall", A2F_FALL, 1'b0);
    ISEL = 1'b0; #1;
    chk("byp_off_a2f", A2F, 1'b0);

    // reset mid filter count
    IFILT = 1'b1; IP = 1'b1;
    tick(); tick(); tick();
    QRT = 1'b1;
    tick();
    chk("mrst_a2f", A2F, 1'b0);
    chk("mrst_valid", A2F_VALID, 1'b0);
    chk("mrst_rise", A2F_RISE, 1'b0);
    QRT = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("mrst_wait_a2f", A2F, 1'b0);
      chk("mrst_wait_rise", A2F_RISE, 1'b0);
      chk("mrst_valid_seq", A2F_VALID, (i >= 2));
    end
    tick(); chk("mrst7_a2f", A2F, 1'b1); chk("mrst7_rise", A2F_RISE, 1'b1);
    tick(); chk("mrst8_rise", A2F_RISE, 1'b0); chk("mrst8_a2f", A2F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
